// File: rtl/csa_accum_pkg.sv
// Shared types and helpers for the carry-save accumulator.
package csa_accum_pkg;

    // Top-level control states of the accumulator
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

    // Number of carry-propagate chunks needed to resolve the redundant pair
    function automatic int calc_nchunk(input int acc_w, input int cpa_w);
        return acc_w / cpa_w;
    endfunction

    // Width of the chunk index; kept at least one bit wide for the single-chunk case
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/csa_accum_row.sv
// One row of 3:2 compressors: three W-bit vectors reduced to a sum and a carry vector.
module csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    // Bitwise full-adder: sum is the parity, carry is the majority of the three inputs
    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/csa_accum.sv
// Sequential carry-save accumulator with a chunked final carry-propagate add.
module csa_accum
    import csa_accum_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int ACC_W  = 32,
    parameter int CPA_W  = 8,
    parameter int SIGNED = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int NCHUNK = calc_nchunk(ACC_W, CPA_W);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Reject parameter sets the chunked adder cannot handle
    if ((ACC_W % CPA_W) != 0 || IN_W > ACC_W) begin : g_param_check
        $error("csa_accum: ACC_W must be a multiple of CPA_W and IN_W must not exceed ACC_W");
    end

    state_t           state;
    logic [ACC_W-1:0] s_reg;
    logic [ACC_W-1:0] c_reg;
    logic [ACC_W-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             cy;
    logic [CNT_W-1:0] count;

    logic [ACC_W-1:0] ext_data;
    logic [ACC_W-1:0] row_s;
    logic [ACC_W-1:0] row_co;
    logic [CPA_W:0]   chunk_sum;
    logic [ACC_W-1:0] res_next;
    logic             accept;

    // Operand widening and handshake decode
    always_comb begin
        if (SIGNED != 0) begin
            ext_data = ACC_W'($signed(in_data));
        end else begin
            ext_data = ACC_W'(in_data);
        end
        in_ready = (state == IDLE) || (state == ACC);
        accept   = in_valid && in_ready;
    end

    csa_row #(.W(ACC_W)) u_row (
        .a  (s_reg),
        .b  (c_reg),
        .c  (ext_data),
        .s  (row_s),
        .co (row_co)
    );

    // Add the currently selected chunk of S and C plus the carry from the previous chunk
    always_comb begin
        chunk_sum = {1'b0, s_reg[int'(idx) * CPA_W +: CPA_W]}
                  + {1'b0, c_reg[int'(idx) * CPA_W +: CPA_W]}
                  + (CPA_W + 1)'(cy);
        res_next  = res;
        res_next[int'(idx) * CPA_W +: CPA_W] = chunk_sum[CPA_W-1:0];
    end

    // Control FSM plus datapath registers; the result is latched on the last resolve cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            res       <= '0;
            idx       <= '0;
            cy        <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_reg <= ext_data;
                        c_reg <= '0;
                        count <= CNT_W'(1);
                        if (in_last) begin
                            state <= RESOLVE;
                            idx   <= '0;
                            cy    <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        s_reg <= row_s;
                        c_reg <= row_co << 1;
                        if (count != '1) begin
                            count <= count + CNT_W'(1);
                        end
                        if (in_last) begin
                            state <= RESOLVE;
                            idx   <= '0;
                            cy    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res <= res_next;
                    cy  <= chunk_sum[CPA_W];
                    if (idx == LAST_IDX) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= res_next;
                        out_count <= count;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
